mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Single-port bus arbiter and sequencer for the SoC's shared memory/IO bus.
- Arbitrates between the IF-stage instruction fetch port (read-only) and the MEM-stage data port (load/store, 4-bit byte-write enable).
- Inserts per-region wait states and returns one-cycle acknowledges.
- Drives pipeline stall requests while a port's access is outstanding. Sits between the IF/MEM stages and the RAM and `interfaces` IO block.

Parameters:
- IO_BASE, 32'hFFFF_FC00, addresses >= IO_BASE are IO region; below is memory region.
- MEM_WAIT, 1, wait states for a memory-region access (0..2^CNT_W-1).
- IO_WAIT, 3, wait states for an IO-region access (0..2^CNT_W-1).
- CNT_W, 4, wait-state counter width.

Ports:
- clk  in  1  system clock (from divclk)
- clrn  in  1  asynchronous active-low reset
- i_req  in  1  instruction fetch request; held until i_ack
- i_addr  in  32  fetch address; stable while i_req
- i_rdata  out  32  fetched word; valid in i_ack cycle, held until next instr grant completes
- i_ack  out  1  one-cycle completion pulse, instruction port
- stall_if  out  1  i_req & ~i_ack (combinational)
- d_req  in  1  data request; held until d_ack
- d_addr  in  32  data address; stable while d_req
- d_we  in  4  byte write enables; 4'b0000 = read
- d_wdata  in  32  write data; stable while d_req
- d_rdata  out  32  load data; valid in d_ack cycle, held until next data read completes
- d_ack  out  1  one-cycle completion pulse, data port
- stall_mem  out  1  d_req & ~d_ack (combinational)
- bus_addr  out  32  shared bus address
- bus_wdata  out  32  shared bus write data
- bus_be  out  4  byte enables to bus (d_we for writes, 4'b1111 for reads)
- bus_rd  out  1  read strobe
- bus_wr  out  1  write strobe
- bus_rdata  in  32  read data from memory/IO mux; sampled on final BUSY cycle
- bus_io  out  1  high while the granted access targets the IO region

Behaviour:
- Reset (clrn=0, async):
  - State IDLE; all outputs 0.
  - cnt=0; owner=none; rr pointer = data-first.
  - Any in-flight access is abandoned with no ack.
- States: IDLE, BUSY.
- IDLE arbitration:
  - Eligible requesters are those with req=1 and ack currently 0. A requester whose ack is high this cycle is ignored, so no double grant.
  - One eligible requester is granted.
  - Both eligible: the rr pointer wins. After any grant, the pointer points to the other port (alternating on contention).
  - On grant: latch owner, address, wdata and be into bus registers; bus_io = (addr >= IO_BASE, unsigned); cnt = bus_io ? IO_WAIT : MEM_WAIT; go to BUSY.
- BUSY:
  - bus_rd/bus_wr asserted every cycle. bus_wr = owner is data and be != 0; bus_rd otherwise.
  - Bus address, data and be are constant throughout.
  - cnt != 0: decrement.
  - cnt == 0: at that edge, capture bus_rdata into i_rdata, or into d_rdata for a data read. Pulse the owner's ack for exactly one cycle, deassert strobes and bus_io, go to IDLE.
  - A data write does not modify d_rdata.
- Latency: request visible in cycle 0 → ack high in cycle W+2, where W is the region's wait count. Strobes are high in cycles 1..W+1.
- Throughput:
  - Minimum gap between grants is one IDLE cycle (the ack cycle).
  - A competing requester is granted in the ack cycle of the previous owner.
- Requests arriving while BUSY wait; no queueing beyond the two ports.
- Dropping req before ack is illegal. The arbiter still completes the access and pulses ack.
- Address arithmetic: unsigned 32-bit compare only; no alignment checking.
- Counter: CNT_W bits, never wraps (loaded only in IDLE).

Test Plan:
- Reset mid-access:
  - Data read to 0x0000_0010 with MEM_WAIT=1; clrn low in first BUSY cycle.
  - Outputs 0 immediately; no d_ack after release; a new i_req after release is granted normally.
- Single fetch:
  - i_req, i_addr=0x0000_0040, bus_rdata=0x2008_0005.
  - bus_rd high cycles 1–2; i_ack in cycle 3; i_rdata=0x2008_0005; stall_if high cycles 0–2.
- IO write:
  - d_req, d_addr=0xFFFF_FC60, d_we=4'b0011, d_wdata=0x0000_ABCD.
  - bus_wr and bus_io high cycles 1–4, bus_be=4'b0011; d_ack in cycle 5; d_rdata unchanged.
- Contention:
  - i_req and d_req both asserted from reset, held, re-requesting after each ack.
  - Grants alternate D, I, D, I. Each second grant starts in the previous ack cycle. No port receives two consecutive grants while the other is pending.
- Region boundary:
  - Data reads to 0xFFFF_FBFC and 0xFFFF_FC00.
  - First takes MEM_WAIT (ack cycle 3, bus_io=0); second takes IO_WAIT (ack cycle 5, bus_io=1).
- No double grant: requester holds req through its ack cycle and drops it the following cycle → exactly one ack, one BUSY sequence.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
`timescale 1ns/1ps
// mem_bus_arbiter
//   Single-port arbiter/sequencer for the shared memory/IO bus. Grants either
//   the instruction-fetch port (read only) or the data port (load/store), holds
//   the bus for a region-dependent number of wait states, captures read data
//   on the last busy cycle and returns a one-cycle acknowledge to the owner.
//
//   Ports
//     clk, clrn                 clock, asynchronous active-low reset
//     i_req/i_addr              fetch request (held until i_ack)
//     i_rdata/i_ack/stall_if    fetch response, completion pulse, stall
//     d_req/d_addr/d_we/d_wdata data request (d_we == 0 means read)
//     d_rdata/d_ack/stall_mem   data response, completion pulse, stall
//     bus_addr/bus_wdata/bus_be shared bus request fields
//     bus_rd/bus_wr/bus_io      strobes and IO-region flag
//     bus_rdata                 read data returned from the memory/IO mux
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | no access in flight; arbitrate between eligible requesters
//   BUSY   | bus owned; strobes high, wait counter running down to zero
module mem_bus_arbiter #(
  parameter logic [31:0] IO_BASE  = 32'hFFFF_FC00,
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned IO_WAIT  = 3,
  parameter int unsigned CNT_W    = 4
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  output logic        stall_if,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        stall_mem,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  output logic        bus_rd,
  output logic        bus_wr,
  input  logic [31:0] bus_rdata,
  output logic        bus_io
);

  typedef enum logic {S_IDLE, S_BUSY} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_e;

  localparam logic [CNT_W-1:0] MEM_CNT = CNT_W'(MEM_WAIT);
  localparam logic [CNT_W-1:0] IO_CNT  = CNT_W'(IO_WAIT);

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rr_data_q, rr_data_d;   // 1: data port wins on contention
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic             io_q, io_d;
  logic             i_ack_q, i_ack_d;
  logic             d_ack_q, d_ack_d;
  logic [31:0]      i_rdata_q, i_rdata_d;
  logic [31:0]      d_rdata_q, d_rdata_d;

  logic        i_elig, d_elig, grant_i, grant_d;
  logic [31:0] sel_addr;
  logic        sel_io, sel_wr;

  // A port whose ack is high this cycle has just been served; masking it
  // prevents a second grant from the still-held request.
  assign i_elig  = i_req & ~i_ack_q;
  assign d_elig  = d_req & ~d_ack_q;
  assign grant_d = d_elig & (~i_elig | rr_data_q);
  assign grant_i = i_elig & ~grant_d;

  assign sel_addr = grant_d ? d_addr : i_addr;
  assign sel_io   = (sel_addr >= IO_BASE);
  assign sel_wr   = grant_d & (|d_we);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    rr_data_d = rr_data_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    io_d      = io_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (grant_i || grant_d) begin
          owner_d   = grant_d ? OWN_D : OWN_I;
          rr_data_d = grant_i;
          addr_d    = sel_addr;
          wdata_d   = grant_d ? d_wdata : 32'h0;
          be_d      = sel_wr ? d_we : 4'b1111;
          io_d      = sel_io;
          cnt_d     = sel_io ? IO_CNT : MEM_CNT;
          wr_d      = sel_wr;
          rd_d      = ~sel_wr;
          state_d   = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (owner_q == OWN_D) begin
            d_ack_d = 1'b1;
            if (!wr_q) d_rdata_d = bus_rdata;
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = bus_rdata;
          end
          owner_d = OWN_NONE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          io_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_NONE;
      cnt_q     <= '0;
      rr_data_q <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      io_q      <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      rr_data_q <= rr_data_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      io_q      <= io_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign i_rdata   = i_rdata_q;
  assign i_ack     = i_ack_q;
  assign stall_if  = i_req & ~i_ack_q;
  assign d_rdata   = d_rdata_q;
  assign d_ack     = d_ack_q;
  assign stall_mem = d_req & ~d_ack_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_be    = be_q;
  assign bus_rd    = rd_q;
  assign bus_wr    = wr_q;
  assign bus_io    = io_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_ack, stall_if;
  logic        d_req = 1'b0;
  logic [31:0] d_addr = '0;
  logic [3:0]  d_we = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack, stall_mem;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        bus_rd, bus_wr, bus_io;

  mem_bus_arbiter dut (
    .clk(clk), .clrn(clrn),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .stall_if(stall_if),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .stall_mem(stall_mem),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_rdata(bus_rdata), .bus_io(bus_io)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus device: garbage unless a read strobe is up, so late/early sampling shows.
  assign bus_rdata = !bus_rd ? 32'hDEAD_BEEF :
                     (bus_addr == 32'h0000_0040) ? 32'h2008_0005 :
                     (bus_addr ^ 32'h5A5A_5A5A);

  typedef struct {
    bit          port_d;
    int          ack_cyc;
    logic [31:0] rdata;
    int          nstb;
    logic [31:0] addr;
    logic [3:0]  be;
    bit          wr;
    bit          io;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Monitor / scoreboard
  bit          active = 0;
  int          nstb = 0;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;
  bit          s_wr, s_io, changed, all_st_i, all_st_d;

  always @(negedge clk) begin
    exp_t e;
    if (!clrn) begin
      active = 0;
      chk("reset_outputs",
          32'({i_ack, d_ack, bus_rd, bus_wr, bus_io, bus_be}), 32'h0);
      chk("reset_bus_addr", bus_addr, 32'h0);
      chk("reset_bus_wdata", bus_wdata, 32'h0);
      chk("reset_i_rdata", i_rdata, 32'h0);
      chk("reset_d_rdata", d_rdata, 32'h0);
    end else begin
      if (bus_rd || bus_wr) begin
        if (!active) begin
          active = 1; nstb = 0; changed = 0;
          s_addr = bus_addr; s_wdata = bus_wdata; s_be = bus_be;
          s_wr = bus_wr; s_io = bus_io;
          all_st_i = 1; all_st_d = 1;
        end else if (bus_addr !== s_addr || bus_wdata !== s_wdata || bus_be !== s_be ||
                     bus_wr !== s_wr || bus_rd !== !s_wr || bus_io !== s_io) begin
          changed = 1;
        end
        nstb++;
        all_st_i &= (stall_if === 1'b1);
        all_st_d &= (stall_mem === 1'b1);
      end
      if (i_ack || d_ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 32'({i_ack, d_ack}), 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("ack_port", 32'({i_ack, d_ack}), e.port_d ? 32'h1 : 32'h2);
          chk("ack_cycle", cyc, e.ack_cyc);
          chk("rdata", e.port_d ? d_rdata : i_rdata, e.rdata);
          chk("strobe_cycles", nstb, e.nstb);
          chk("bus_addr", s_addr, e.addr);
          chk("bus_be", 32'(s_be), 32'(e.be));
          chk("bus_wr", 32'(s_wr), 32'(e.wr));
          chk("bus_io", 32'(s_io), 32'(e.io));
          if (e.wr) chk("bus_wdata", s_wdata, e.wdata);
          chk("bus_stable", 32'(changed), 32'h0);
          chk("stall_busy", 32'(e.port_d ? all_st_d : all_st_i), 32'h1);
          chk("stall_ack", 32'(e.port_d ? stall_mem : stall_if), 32'h0);
          chk("strobes_off_at_ack", 32'({bus_rd, bus_wr, bus_io}), 32'h0);
        end
        active = 0;
      end
      if (exp_q.size() > 0 && cyc > exp_q[0].ack_cyc) begin
        e = exp_q.pop_front();
        chk("ack_missing", 32'(cyc), 32'(e.ack_cyc));
      end
    end
  end

  // Driver
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push(input bit is_d, input int ack_cyc, input logic [31:0] addr,
                      input logic [3:0] be, input bit wr, input bit io,
                      input logic [31:0] wdata, input logic [31:0] rdata, input int nst);
    exp_t e;
    e.port_d = is_d; e.ack_cyc = ack_cyc; e.addr = addr; e.be = be; e.wr = wr;
    e.io = io; e.wdata = wdata; e.rdata = rdata; e.nstb = nst;
    exp_q.push_back(e);
  endtask

  task automatic access(input bit is_d, input logic [31:0] addr, input logic [3:0] we,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input int lat, input logic [3:0] be, input bit wr, input bit io);
    push(is_d, cyc + lat, addr, be, wr, io, wdata, exp_rd, lat - 1);
    if (is_d) begin
      d_req = 1'b1; d_addr = addr; d_we = we; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    for (int k = 0; k < 30; k++) begin
      tick();
      if (is_d ? d_ack : i_ack) break;
    end
    tick();  // hold req through the ack cycle, drop afterwards
    if (is_d) d_req = 1'b0; else i_req = 1'b0;
    idle(4);
  endtask

  int c0;

  initial begin
    idle(3);
    clrn = 1'b1;
    idle(2);

    // Reset in the first busy cycle of a data read: abandoned, no ack later.
    d_req = 1'b1; d_addr = 32'h0000_0010; d_we = 4'b0000;
    tick();
    clrn = 1'b0;
    d_req = 1'b0;
    tick();
    clrn = 1'b1;
    idle(10);

    // Single fetch after reset release.
    access(1'b0, 32'h0000_0040, 4'b0000, 32'h0, 32'h2008_0005, 3, 4'b1111, 1'b0, 1'b0);

    // Region boundary: last memory word, first IO word.
    access(1'b1, 32'hFFFF_FBFC, 4'b0000, 32'h0, 32'hA5A5_A1A6, 3, 4'b1111, 1'b0, 1'b0);
    access(1'b1, 32'hFFFF_FC00, 4'b0000, 32'h0, 32'hA5A5_A65A, 5, 4'b1111, 1'b0, 1'b1);

    // IO write: d_rdata keeps the previous load value.
    access(1'b1, 32'hFFFF_FC60, 4'b0011, 32'h0000_ABCD, 32'hA5A5_A65A, 5, 4'b0011, 1'b1, 1'b1);

    // Contention from reset: both held, grants alternate D, I, D, I.
    clrn = 1'b0;
    i_req = 1'b1; i_addr = 32'h0000_0200;
    d_req = 1'b1; d_addr = 32'h0000_0100; d_we = 4'b0000; d_wdata = 32'h0;
    tick();
    clrn = 1'b1;
    c0 = cyc;
    push(1'b1, c0 + 3,  32'h0000_0100, 4'b1111, 1'b0, 1'b0, 32'h0, 32'h5A5A_5B5A, 2);
    push(1'b0, c0 + 6,  32'h0000_0200, 4'b1111, 1'b0, 1'b0, 32'h0, 32'h5A5A_585A, 2);
    push(1'b1, c0 + 9,  32'h0000_0100, 4'b1111, 1'b0, 1'b0, 32'h0, 32'h5A5A_5B5A, 2);
    push(1'b0, c0 + 12, 32'h0000_0200, 4'b1111, 1'b0, 1'b0, 32'h0, 32'h5A5A_585A, 2);
    repeat (12) tick();
    d_req = 1'b0;   // withdraw the pending data request in the last ack cycle
    tick();
    i_req = 1'b0;
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
